// File: rtl/agc_alu.sv
// -----------------------------------------------------------------------------
// agc_alu
//   Registered 15-bit arithmetic/logic unit for a one's-complement datapath.
//   Operand words carry data in [15:1] and parity in [0]. The parity bit is
//   ignored. The unit computes one result combinationally from the data
//   fields and the command, and registers it on every rising clock edge.
//   Latency is exactly one edge. There is no handshake.
//
// Ports
//   clk      in   1   system clock, rising-edge active
//   reset    in   1   asynchronous, active-high; clears res immediately
//   A        in  16   operand A: [15:1] data, [0] parity (unused)
//   B        in  16   operand B: [15:1] data, [0] parity (unused)
//   command  in   3   0 AD, 1 SU, 2 MASK, 3 MP0, 4 MP1, 5 DV0, 6 DV1, 7 rsvd
//   res      out 15   registered result
// -----------------------------------------------------------------------------
module agc_alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  command,
    output logic [14:0] res
);

    localparam logic [2:0] CMD_AD   = 3'd0;
    localparam logic [2:0] CMD_SU   = 3'd1;
    localparam logic [2:0] CMD_MASK = 3'd2;
    localparam logic [2:0] CMD_MP0  = 3'd3;
    localparam logic [2:0] CMD_MP1  = 3'd4;
    localparam logic [2:0] CMD_DV0  = 3'd5;
    localparam logic [2:0] CMD_DV1  = 3'd6;

    // Data fields. Parity takes no part in any operation.
    logic [14:0] a_data;
    logic [14:0] b_data;
    logic        parity_unused;

    assign a_data        = A[15:1];
    assign b_data        = B[15:1];
    assign parity_unused = A[0] ^ B[0];

    // -------------------------------------------------------------------------
    // One's-complement add / subtract with end-around carry.
    // The largest raw sum is 0x7FFF + 0x7FFF = 0xFFFE. Feeding the carry back
    // therefore can never cause a second carry. -0 (0x7FFF) is kept as-is.
    // -------------------------------------------------------------------------
    logic [15:0] add_raw;
    logic [15:0] sub_raw;
    logic [14:0] add_res;
    logic [14:0] sub_res;

    assign add_raw = {1'b0, a_data} + {1'b0, b_data};
    assign sub_raw = {1'b0, a_data} + {1'b0, ~b_data};
    assign add_res = add_raw[14:0] + {14'd0, add_raw[15]};
    assign sub_res = sub_raw[14:0] + {14'd0, sub_raw[15]};

    // -------------------------------------------------------------------------
    // Unsigned 15x15 multiply, full 30-bit product.
    // -------------------------------------------------------------------------
    logic [29:0] prod;

    assign prod = {15'd0, a_data} * {15'd0, b_data};

    // -------------------------------------------------------------------------
    // Unsigned divide as a fully unrolled restoring array, so it completes in a
    // single cycle. Each step shifts in one dividend bit, MSB first. The step
    // subtracts the divisor when the partial remainder is large enough.
    // The partial remainder always stays below b. It therefore fits in 15 bits.
    // -------------------------------------------------------------------------
    logic [14:0] div_quot;
    logic [14:0] div_rem;
    logic [15:0] div_trial;

    always_comb begin
        div_quot  = '0;
        div_rem   = '0;
        div_trial = '0;
        for (int i = 14; i >= 0; i--) begin
            div_trial = {div_rem, a_data[i]};
            if (div_trial >= {1'b0, b_data}) begin
                div_rem     = 15'(div_trial - {1'b0, b_data});
                div_quot[i] = 1'b1;
            end else begin
                div_rem = div_trial[14:0];
            end
        end
        // Divide by zero: the quotient saturates to all ones and the dividend
        // is returned as the remainder. The array already yields this. The
        // override makes the behaviour explicit and independent of the array.
        if (b_data == 15'd0) begin
            div_quot = 15'h7FFF;
            div_rem  = a_data;
        end
    end

    // -------------------------------------------------------------------------
    // Result select and register.
    // -------------------------------------------------------------------------
    logic [14:0] res_d;
    logic [14:0] res_q;

    always_comb begin
        res_d = '0;
        case (command)
            CMD_AD:   res_d = add_res;
            CMD_SU:   res_d = sub_res;
            CMD_MASK: res_d = a_data & b_data;
            CMD_MP0:  res_d = prod[14:0];
            CMD_MP1:  res_d = prod[29:15];
            CMD_DV0:  res_d = div_quot;
            CMD_DV1:  res_d = div_rem;
            default:  res_d = 15'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res = res_q;

endmodule

// File: tb/tb_agc_alu.sv
// -----------------------------------------------------------------------------
// tb_agc_alu
//   Scoreboard bench for agc_alu. Each transaction drives its inputs on the
//   falling edge and pushes the expected result. The result is popped and
//   compared one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_agc_alu;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  command;
    logic [14:0] res;

    int total_cnt;
    int bad_cnt;

    logic [14:0] exp_q[$];

    agc_alu dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .command (command),
        .res     (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must always end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [14:0] got,
                             input logic [14:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    // Independent behavioural reference built on integer arithmetic.
    function automatic logic [14:0] ref_model(input logic [15:0] av,
                                              input logic [15:0] bv,
                                              input logic [2:0]  c);
        int unsigned     a;
        int unsigned     b;
        int unsigned     s;
        longint unsigned p;
        a = int'(av[15:1]);
        b = int'(bv[15:1]);
        p = longint'(a) * longint'(b);
        s = 0;
        case (c)
            3'd0: begin s = a + b;           if (s > 32767) s = s - 32767; end
            3'd1: begin s = a + (32767 - b); if (s > 32767) s = s - 32767; end
            3'd2: s = a & b;
            3'd3: s = int'(p % 32768);
            3'd4: s = int'((p / 32768) % 32768);
            3'd5: s = (b == 0) ? 32767 : a / b;
            3'd6: s = (b == 0) ? a : a % b;
            default: s = 0;
        endcase
        return s[14:0];
    endfunction

    // Drive one transaction, push its expectation, then compare after the edge.
    task automatic run_op(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic [2:0] c,
                          input logic [14:0] exp);
        logic [14:0] e;
        @(negedge clk);
        A       = av;
        B       = bv;
        command = c;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("txn %-10s A=0x%04h B=0x%04h cmd=%0d res=0x%04h exp=0x%04h",
                 tag, av, bv, c, res, e);
        check_val(tag, res, e);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rc;
        total_cnt = 0;
        bad_cnt   = 0;
        A       = 16'h0000;
        B       = 16'h0000;
        command = 3'd0;

        // Reset acts immediately, without a clock edge.
        reset = 1'b1;
        #1;
        check_val("rst_async", res, 15'h0000);
        @(posedge clk);
        #1;
        check_val("rst_hold", res, 15'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the plan.
        run_op("mp1",     16'hFFFC, 16'hFFF8, 3'd4, 15'h7FFA);
        run_op("mp0",     16'hFFFC, 16'hFFF8, 3'd3, 15'h0008);
        run_op("ad_negz", 16'h0133, 16'hFECC, 3'd0, 15'h7FFF);
        run_op("ad_eac",  16'hFFFC, 16'hFFF8, 3'd0, 15'h7FFB);
        run_op("su",      16'h000A, 16'h0006, 3'd1, 15'h0002);
        run_op("su_par",  16'h000B, 16'h0007, 3'd1, 15'h0002);
        run_op("mask",    16'hAAAA, 16'hFE1E, 3'd2, 15'h5505);
        run_op("mask_par",16'hAAAB, 16'hFE1F, 3'd2, 15'h5505);
        run_op("dv0",     16'h00C8, 16'h000E, 3'd5, 15'd14);
        run_op("dv1",     16'h00C8, 16'h000E, 3'd6, 15'd2);
        run_op("dv0_z",   16'h1234, 16'h0001, 3'd5, 15'h7FFF);
        run_op("dv1_z",   16'h1234, 16'h0001, 3'd6, 15'h091A);
        run_op("rsvd",    16'hFFFF, 16'hFFFF, 3'd7, 15'h0000);
        run_op("dv0_b",   16'h00C8, 16'h000E, 3'd5, 15'd14);

        // Command changes between edges: res must hold until the next edge.
        @(negedge clk);
        command = 3'd4;
        #2;
        command = 3'd6;
        exp_q.push_back(15'd2);
        #1;
        check_val("mid_hold", res, 15'd14);
        @(posedge clk);
        #1;
        $display("txn %-10s A=0x%04h B=0x%04h cmd=%0d res=0x%04h exp=0x%04h",
                 "mid_chg", A, B, command, res, exp_q[0]);
        check_val("mid_chg", res, exp_q.pop_front());

        // Reset asserted mid-cycle with a nonzero result.
        run_op("pre_rst", 16'hFFFC, 16'hFFF8, 3'd4, 15'h7FFA);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid", res, 15'h0000);
        @(posedge clk);
        #1;
        check_val("rst_mid_hold", res, 15'h0000);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 16'h000A, 16'h0006, 3'd0, 15'd8);

        // Randomised sweep against the reference model.
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 3'($urandom_range(0, 7));
            if (i % 16 == 0) rb[15:1] = 15'd0;
            if (i % 16 == 1) rb = {~ra[15:1], ra[0]};
            run_op("rand", ra, rb, rc, ref_model(ra, rb, rc));
        end

        if (exp_q.size() != 0) begin
            total_cnt++;
            bad_cnt++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/agc_alu.md
Name: agc_alu

Overview:
- Registered 15-bit arithmetic/logic unit for the one's-complement datapath.
- Operands arrive as 16-bit words: bits [15:1] carry data and bit [0] carries parity.
- It performs add, subtract, mask, multiply (low/high word) and divide (quotient/remainder) on the data fields.
- The selected result is registered onto a 15-bit output on every clock edge.

Parameters:
- None. All widths are fixed: 16-bit operand words, 15-bit data, 3-bit command.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears the result register
- A  input  16  operand A; [15:1] data, [0] parity (ignored)
- B  input  16  operand B; [15:1] data, [0] parity (ignored)
- command  input  3  operation select
- res  output  15  registered result

Behaviour:
- Data fields: a = A[15:1], b = B[15:1]. Parity bits A[0] and B[0] take no part in any operation.
- Command encoding:
  - 0 AD
  - 1 SU
  - 2 MASK
  - 3 MP0
  - 4 MP1
  - 5 DV0
  - 6 DV1
  - 7 reserved
- AD: one's-complement add. s = a + b, 16-bit. The carry out of bit 14 is added back into bit 0 (end-around carry). The result is the low 15 bits.
  - No conversion of -0 (0x7FFF) to +0: x + (-x) = 0x7FFF.
  - Overflow is ignored; no flags.
- SU: one's-complement subtract. Computed as a + (~b) with end-around carry, same rules as AD.
- MASK: a & b, bitwise.
- MP0/MP1: unsigned 15x15 multiply giving a 30-bit product p = a * b.
  - MP0 returns p[14:0], the low word.
  - MP1 returns p[29:15], the high word.
- DV0/DV1: unsigned division a / b.
  - DV0 returns the 15-bit quotient; DV1 returns the 15-bit remainder.
  - Divide by zero (b == 0): quotient = 0x7FFF, remainder = a.
- Reserved command 7 produces 0x0000.
- Timing:
  - The result is computed combinationally from A, B and command.
  - It is captured into res on every rising clk edge.
  - Latency is one clock edge. There is no start/done handshake; res tracks its inputs continuously with one-cycle delay.
  - Changing A, B or command mid-stream affects only the next edge's capture.
  - The multiply/divide logic must meet single-cycle timing. A pipelined implementation is not permitted; latency is exactly 1.
- Reset:
  - While reset is high, res = 0x0000 immediately, independent of clk, and is held at 0.
  - The first capture occurs on the first rising edge after reset deasserts.
- res never shows X once reset has been applied.

Test Plan:
- Reset: assert reset mid-cycle with a nonzero res -> res becomes 0x0000 without waiting for a clock edge; stays 0 while reset is high.
- MP1/MP0: a = 0x7FFE, b = 0x7FFC, i.e. A = 0xFFFC, B = 0xFFF8, parity 0.
  - command = 4 -> res = 0x7FFA after one edge.
  - command = 3 -> res = 0x0008.
- AD of ±x: A = 0x0133 (a = 153), B = 0xFECC (b = 0x7F66, i.e. -153), command = 0 -> res = 0x7FFF (-0).
- AD end-around carry: a = 0x7FFE (-1), b = 0x7FFC (-3) -> res = 0x7FFB (-4).
- SU and MASK:
  - SU with a = 5, b = 3 -> res = 0x0002.
  - MASK with a = 0x5555, b = 0x7F0F -> res = 0x5505.
  - Toggling the parity bits leaves both results unchanged.
- DV:
  - a = 100, b = 7: DV0 -> 14, DV1 -> 2.
  - b = 0: DV0 -> 0x7FFF, DV1 -> a.
  - command = 7 -> 0x0000.
  - Changing command between edges -> res updates only on the next rising edge.
